// File: rtl/mem_arb.sv
// mem_arb: multi-cycle arbiter between three core bus masters and one slave port.
//
// Masters: m0 = EX load/store, m1 = PC fetch (read only), m2 = JTAG debug.
// Priority is m2 > m0 > m1. After STARVE_MAX consecutive lost arbitrations,
// a waiting fetch (m1) wins the next decision outright, including over m2.
//
// Handshake: a master raises mX_req_i and holds it, with stable address and
// data, until mX_ack_o. The arbiter latches the winner's address, we and
// wdata, then holds s_req_o high with those values until the slave pulses
// s_ack_i for one cycle. That same cycle the winner sees mX_ack_o=1 and
// mX_rdata_o=s_rdata_i, combinationally. Every rdata output is 0 while its
// ack is 0. One IDLE cycle always separates two transactions. A request
// still high in the cycle after its ack counts as a new request.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   m0_*            EX port: req/we/addr/wdata in; rdata/ack out
//   m1_*            fetch port: req/addr in; rdata/ack out
//   m2_*            JTAG port: req/we/addr/wdata in; rdata/ack out
//   s_*             slave port: req/we/addr/wdata out; rdata/ack in
//   err_o           watchdog expiry pulse (only with MEM_ARB_TIMEOUT_EN)
//   hold_flag_o     pipeline stall while an m0 or m1 access is pending
//
// Build option MEM_ARB_TIMEOUT_EN: a BUSY cycle counter. When it reaches
// TIMEOUT without s_ack_i, the arbiter force-acks the granted master with
// rdata 0, pulses err_o, drops s_req_o and returns to IDLE.
module mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  output logic [DATA_W-1:0] m2_rdata_o,
  output logic              m2_ack_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_ack_i,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              err_o,
`endif
  output logic              hold_flag_o
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {G_NONE, G_M0, G_M1, G_M2} grant_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // State is kept in named registers so checkers can bind to state_q/grant_q.
  state_t              state_q, state_d;
  grant_t              grant_q, grant_d;
  grant_t              win;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy;
  logic                slave_done;  // real slave completion this cycle
  logic                done_any;    // any completion (slave or watchdog)

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                forced;
`endif

  assign busy = (state_q == BUSY);

  // Winner of the current IDLE decision. The starvation boost is checked
  // first so it can override the JTAG port as well.
  always_comb begin
    win = G_NONE;
    if (m1_req_i && (starve_q == STARVE_LIM)) win = G_M1;
    else if (m2_req_i)                        win = G_M2;
    else if (m0_req_i)                        win = G_M0;
    else if (m1_req_i)                        win = G_M1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    s_req_o    = 1'b0;
    slave_done = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
    forced     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d = '0;
`endif
        // Saturating count of fetch losses; cleared on a fetch win or no fetch.
        if (m1_req_i && (win != G_M1))
          starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        else
          starve_d = 4'd0;
        if (win != G_NONE) begin
          state_d = BUSY;
          grant_d = win;
          case (win)
            G_M0: begin addr_d = m0_addr_i; we_d = m0_we_i; wdata_d = m0_wdata_i; end
            G_M1: begin addr_d = m1_addr_i; we_d = 1'b0;    wdata_d = '0;         end
            G_M2: begin addr_d = m2_addr_i; we_d = m2_we_i; wdata_d = m2_wdata_i; end
            default: ;
          endcase
        end
      end
      BUSY: begin
        s_req_o = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        if (tmo_q == TMO_LIM) begin
          // Watchdog expiry: slave request is withdrawn, any late ack ignored.
          s_req_o = 1'b0;
          forced  = 1'b1;
          state_d = IDLE;
          grant_d = G_NONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (s_ack_i) begin
            slave_done = 1'b1;
            state_d    = IDLE;
            grant_d    = G_NONE;
          end
        end
`else
        if (s_ack_i) begin
          slave_done = 1'b1;
          state_d    = IDLE;
          grant_d    = G_NONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= G_NONE;
      starve_q <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign done_any = slave_done | forced;
  assign err_o    = forced;
`else
  assign done_any = slave_done;
`endif

  // Slave side is driven only while BUSY so it reads 0 between transactions.
  assign s_we_o    = busy & we_q;
  assign s_addr_o  = busy ? addr_q  : '0;
  assign s_wdata_o = busy ? wdata_q : '0;

  assign m0_ack_o = done_any & (grant_q == G_M0);
  assign m1_ack_o = done_any & (grant_q == G_M1);
  assign m2_ack_o = done_any & (grant_q == G_M2);

  // Read data is passed through only on a real slave completion.
  assign m0_rdata_o = (slave_done && grant_q == G_M0) ? s_rdata_i : '0;
  assign m1_rdata_o = (slave_done && grant_q == G_M1) ? s_rdata_i : '0;
  assign m2_rdata_o = (slave_done && grant_q == G_M2) ? s_rdata_i : '0;

  // JTAG never stalls the pipeline.
  assign hold_flag_o = (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o);

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
  localparam int W = 35;  // {ack one-hot m2,m1,m0 ; rdata}

  logic        clk, rst;
  logic        m0_req_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic        m0_ack_o;
  logic        m1_req_i;
  logic [31:0] m1_addr_i, m1_rdata_o;
  logic        m1_ack_o;
  logic        m2_req_i, m2_we_i;
  logic [31:0] m2_addr_i, m2_wdata_i, m2_rdata_o;
  logic        m2_ack_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic        s_ack_i;
  logic        hold_flag_o;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err_o;
`endif

  mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_rdata_o(m1_rdata_o),
    .m1_ack_o(m1_ack_o),
    .m2_req_i(m2_req_i), .m2_we_i(m2_we_i), .m2_addr_i(m2_addr_i),
    .m2_wdata_i(m2_wdata_i), .m2_rdata_o(m2_rdata_o), .m2_ack_o(m2_ack_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
`ifdef MEM_ARB_TIMEOUT_EN
    .err_o(err_o),
`endif
    .hold_flag_o(hold_flag_o)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [2:0]  req;      // {m2, m1, m0}
    logic        s_ack;
    logic [31:0] s_rdata;
    logic        e_sreq;
    logic        e_swe;
    logic [31:0] e_saddr;
    logic [31:0] e_swdata;
    logic [2:0]  e_ack;    // {m2, m1, m0}
    logic [31:0] e_rdata;  // for the acked master; others expect 0
    logic        e_hold;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input string name, input logic [2:0] req,
                              input logic s_ack, input logic [31:0] s_rdata,
                              input logic e_sreq, input logic e_swe,
                              input logic [31:0] e_saddr, input logic [31:0] e_swdata,
                              input logic [2:0] e_ack, input logic [31:0] e_rdata,
                              input logic e_hold);
    vec_t v;
    v.name = name; v.req = req; v.s_ack = s_ack; v.s_rdata = s_rdata;
    v.e_sreq = e_sreq; v.e_swe = e_swe; v.e_saddr = e_saddr; v.e_swdata = e_swdata;
    v.e_ack = e_ack; v.e_rdata = e_rdata; v.e_hold = e_hold;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_masters(input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1,
                             input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_addr_i = a1;
    m2_we_i = w2; m2_addr_i = a2; m2_wdata_i = d2;
  endtask

  // Called 1 time unit after a rising edge; checks 3 units later.
  task automatic apply_vec(input vec_t v);
    {m2_req_i, m1_req_i, m0_req_i} = v.req;
    s_ack_i   = v.s_ack;
    s_rdata_i = v.s_rdata;
    if (v.e_ack != 3'b000) exp_q.push_back({v.e_ack, v.e_rdata});
    #3;
    chk({v.name, ".s_req"},   32'(s_req_o),   32'(v.e_sreq));
    chk({v.name, ".s_we"},    32'(s_we_o),    32'(v.e_swe));
    chk({v.name, ".s_addr"},  s_addr_o,       v.e_saddr);
    chk({v.name, ".s_wdata"}, s_wdata_o,      v.e_swdata);
    chk({v.name, ".acks"},    32'({m2_ack_o, m1_ack_o, m0_ack_o}), 32'(v.e_ack));
    chk({v.name, ".m0_rdata"}, m0_rdata_o, v.e_ack[0] ? v.e_rdata : 32'h0);
    chk({v.name, ".m1_rdata"}, m1_rdata_o, v.e_ack[1] ? v.e_rdata : 32'h0);
    chk({v.name, ".m2_rdata"}, m2_rdata_o, v.e_ack[2] ? v.e_rdata : 32'h0);
    chk({v.name, ".hold"},    32'(hold_flag_o), 32'(v.e_hold));
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      apply_vec(vecs[i]);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [2:0]   mon_ack;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    mon_ack = {m2_ack_o, m1_ack_o, m0_ack_o};
    if (!rst && mon_ack != 3'b000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack: got ack=%b data=%h required no ack",
                 mon_ack, m0_rdata_o | m1_rdata_o | m2_rdata_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mon_ack, m0_rdata_o | m1_rdata_o | m2_rdata_o} !== mon_exp) begin
          bad++;
          $display("FAIL sb_ack: got ack=%b data=%h required ack=%b data=%h",
                   mon_ack, m0_rdata_o | m1_rdata_o | m2_rdata_o,
                   mon_exp[W-1:32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- test ----------------
  initial begin : main
    int          n_busy;
    logic        seen;
    logic [31:0] exp_addr;
    logic [2:0]  exp_win;

    rst = 1'b1;
    m0_req_i = 0; m1_req_i = 0; m2_req_i = 0; s_ack_i = 0; s_rdata_i = '0;
    set_masters(0, 0, 0, 0, 0, 0, 0);

    // Phase A: m0 read, 2 wait states.
    vecs[0]  = mk("a_idle",  3'b001, 0, 0,            0, 0, 0,            0, 3'b000, 0,            1);
    vecs[1]  = mk("a_wait1", 3'b001, 0, 0,            1, 0, 32'h10000004, 0, 3'b000, 0,            1);
    vecs[2]  = mk("a_wait2", 3'b001, 0, 0,            1, 0, 32'h10000004, 0, 3'b000, 0,            1);
    vecs[3]  = mk("a_ack",   3'b001, 1, 32'hDEADBEEF, 1, 0, 32'h10000004, 0, 3'b001, 32'hDEADBEEF, 0);
    vecs[4]  = mk("a_done",  3'b000, 0, 0,            0, 0, 0,            0, 3'b000, 0,            0);
    // Phase B: m2 write with 0-wait slave; stray ack in IDLE ignored.
    vecs[5]  = mk("b_idle",  3'b100, 0, 0,            0, 0, 0,     0,            3'b000, 0,            0);
    vecs[6]  = mk("b_ack",   3'b100, 1, 32'h12345678, 1, 1, 32'h10, 32'h5A5A5A5A, 3'b100, 32'h12345678, 0);
    vecs[7]  = mk("b_stray", 3'b000, 1, 32'hFFFFFFFF, 0, 0, 0,     0,            3'b000, 0,            0);
    // Phase C: all three request together: m2, then m0, then m1.
    vecs[8]  = mk("c_idle0", 3'b111, 0, 0,     0, 0, 0,       0,            3'b000, 0,     1);
    vecs[9]  = mk("c_m2",    3'b111, 1, 32'hA2, 1, 0, 32'h300, 32'hCAFE0002, 3'b100, 32'hA2, 1);
    vecs[10] = mk("c_idle1", 3'b011, 0, 0,     0, 0, 0,       0,            3'b000, 0,     1);
    vecs[11] = mk("c_m0",    3'b011, 1, 32'hA0, 1, 0, 32'h100, 32'hCAFE0000, 3'b001, 32'hA0, 1);
    vecs[12] = mk("c_idle2", 3'b010, 0, 0,     0, 0, 0,       0,            3'b000, 0,     1);
    vecs[13] = mk("c_m1",    3'b010, 1, 32'hA1, 1, 0, 32'h200, 0,            3'b010, 32'hA1, 0);
    vecs[14] = mk("c_done",  3'b000, 0, 0,     0, 0, 0,       0,            3'b000, 0,     0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_req", 32'(s_req_o), 0);
    chk("rst.acks",  32'({m2_ack_o, m1_ack_o, m0_ack_o}), 0);
    chk("rst.s_addr", s_addr_o, 0);
    chk("rst.hold",  32'(hold_flag_o), 0);
    rst = 1'b0;

    set_masters(0, 32'h10000004, 0, 0, 0, 0, 0);
    run_vecs(0, 4);
    set_masters(0, 0, 0, 0, 1, 32'h10, 32'h5A5A5A5A);
    run_vecs(5, 7);
    set_masters(0, 32'h100, 32'hCAFE0000, 32'h200, 0, 32'h300, 32'hCAFE0002);
    run_vecs(8, 14);

    // Phase D: fetch starvation. m0 and m1 held high, 0-wait slave.
    // m1 must win arbitrations 4 and 9 (boost fires, count clears, fires again).
    set_masters(0, 32'h700, 0, 32'h800, 0, 0, 0);
    m0_req_i = 1; m1_req_i = 1; m2_req_i = 0; s_ack_i = 1;
    for (int k = 0; k < 10; k++) begin
      s_rdata_i = 32'hB0000000 + 32'(k);
      #3;
      chk($sformatf("d_idle%0d.s_req", k), 32'(s_req_o), 0);
      @(posedge clk); #1;
      exp_win  = (k == 4 || k == 9) ? 3'b010 : 3'b001;
      exp_addr = (k == 4 || k == 9) ? 32'h800 : 32'h700;
      exp_q.push_back({exp_win, 32'hB0000000 + 32'(k)});
      #3;
      chk($sformatf("d_busy%0d.s_addr", k), s_addr_o, exp_addr);
      chk($sformatf("d_busy%0d.hold", k), 32'(hold_flag_o), 1);
      @(posedge clk); #1;
    end
    m0_req_i = 0; m1_req_i = 0; s_ack_i = 0; s_rdata_i = 0;

    // Phase E: asynchronous reset during a BUSY m0 read.
    set_masters(0, 32'h4000, 0, 0, 0, 0, 0);
    m0_req_i = 1;
    @(posedge clk); #1;
    chk("e_busy.s_req", 32'(s_req_o), 1);
    #1 rst = 1'b1;
    #1 s_ack_i = 1; s_rdata_i = 32'h77;
    #1;
    chk("e_rst.s_req",    32'(s_req_o), 0);
    chk("e_rst.m0_ack",   32'(m0_ack_o), 0);
    chk("e_rst.m0_rdata", m0_rdata_o, 0);
    s_ack_i = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("e_rearb_idle.s_req", 32'(s_req_o), 0);
    @(posedge clk); #1;
    exp_q.push_back({3'b001, 32'h600D});
    s_ack_i = 1; s_rdata_i = 32'h600D;
    #3;
    chk("e_rearb.s_addr", s_addr_o, 32'h4000);
    chk("e_rearb.m0_ack", 32'(m0_ack_o), 1);
    @(posedge clk); #1;
    m0_req_i = 0; s_ack_i = 0; s_rdata_i = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Phase F: slave never acks; watchdog forces completion after 64 BUSY cycles.
    set_masters(0, 32'h5000, 0, 0, 0, 0, 0);
    m0_req_i = 1; s_rdata_i = 32'h99;
    #3;
    chk("f_idle.err", 32'(err_o), 0);
    n_busy = 0;
    seen = 1'b0;
    exp_q.push_back({3'b001, 32'h0});
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #4;
      if (m0_ack_o) begin
        seen = 1'b1;
        chk("f_tmo.err",      32'(err_o), 1);
        chk("f_tmo.m0_rdata", m0_rdata_o, 0);
        chk("f_tmo.s_req",    32'(s_req_o), 0);
      end else if (s_req_o) begin
        n_busy++;
      end
    end
    chk("f_tmo.seen", 32'(seen), 1);
    chk("f_tmo.busy_cycles", 32'(n_busy), 64);
    @(posedge clk); #1;
    m0_req_i = 0; s_rdata_i = 0;
    #3;
    chk("f_after.err",   32'(err_o), 0);
    chk("f_after.s_req", 32'(s_req_o), 0);
`endif

    // ---------------- final report ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Multi-cycle memory-port arbiter between the core bus masters and a single slave port.
- Masters: m0 = EX load/store port, m1 = PC fetch port, m2 = JTAG debug port.
- Serialises accesses with a req/ack handshake and applies fixed priority with an anti-starvation boost for fetch.
- Produces hold_flag_o so ctrl stalls the pipeline while core accesses are pending.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive lost arbitrations by m1 before m1 is forced to win (range 1..15).
- TIMEOUT, 64, slave ack watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m0_req_i  in  1  EX access request; held until m0_ack_o.
- m0_we_i  in  1  EX write enable.
- m0_addr_i  in  ADDR_W  EX address.
- m0_wdata_i  in  DATA_W  EX write data.
- m0_rdata_o  out  DATA_W  EX read data; valid when m0_ack_o=1.
- m0_ack_o  out  1  EX access complete.
- m1_req_i  in  1  fetch request (read only).
- m1_addr_i  in  ADDR_W  fetch address.
- m1_rdata_o  out  DATA_W  fetch data.
- m1_ack_o  out  1  fetch complete.
- m2_req_i  in  1  JTAG request.
- m2_we_i  in  1  JTAG write enable.
- m2_addr_i  in  ADDR_W  JTAG address.
- m2_wdata_i  in  DATA_W  JTAG write data.
- m2_rdata_o  out  DATA_W  JTAG read data.
- m2_ack_o  out  1  JTAG access complete.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_rdata_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave completion (single-cycle pulse).
- hold_flag_o  out  1  stall request to ctrl.

Behaviour:
- States: IDLE, BUSY.
- Reset: state=IDLE; grant=none; starve_cnt=0; latched addr/we/wdata=0.
  - All *_ack_o=0, *_rdata_o=0, s_req_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0.
  - hold_flag_o is combinational from requests (0 when none).
- IDLE: if any req is high, pick a winner by the priority rules below.
  - Latch the winner's addr, we and wdata (we=0 for m1) into registers; go BUSY.
  - No request: stay IDLE, s_req_o=0.
- Priority:
  - Default order is m2 > m0 > m1.
  - If starve_cnt==STARVE_MAX and m1_req_i=1, m1 wins outright, including over m2.
- starve_cnt: evaluated at each IDLE decision.
  - m1_req_i=1 and m1 loses: +1, saturating at STARVE_MAX.
  - m1 wins, or m1_req_i=0: cleared.
- BUSY:
  - s_req_o=1; s_we_o, s_addr_o, s_wdata_o come from the latched registers and stay stable for the whole transaction.
  - On s_ack_i=1 (same cycle, combinational): granted master's ack_o=1 and its rdata_o=s_rdata_i. Next state is IDLE.
  - Non-granted ack_o stay 0. rdata_o outputs are 0 when their ack_o=0.
  - s_ack_i while IDLE is ignored.
- Latency: request sampled at edge N gives s_req_o high from cycle N+1; minimum request-to-ack is 1 cycle with a 0-wait slave.
  - One IDLE cycle always separates back-to-back transactions.
  - A req still high in the cycle after ack is treated as a new request.
- Request changes during BUSY do not affect the current transaction. A requester deasserting early is a protocol violation and the transaction still completes.
- hold_flag_o = (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o). m2 never stalls the pipeline.
- An asynchronous rst mid-transaction aborts it immediately: IDLE, s_req_o=0, no ack issued.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A BUSY cycle counter counts up.
  - If it reaches TIMEOUT without s_ack_i, the arbiter asserts the granted master's ack_o for 1 cycle with rdata_o=0, drops s_req_o and returns to IDLE.
  - Adds output err_o (1 bit), a one-cycle pulse coincident with that forced ack.
  - The counter clears on IDLE entry.
- Undefined: no counter and no err_o port; BUSY waits indefinitely.

Test Plan:
- m0 read addr 0x1000_0004, slave acks after 2 wait cycles with 0xDEAD_BEEF -> s_addr_o=0x1000_0004 held 3 cycles; m0_ack_o=1 with m0_rdata_o=0xDEAD_BEEF; hold_flag_o=1 until the ack cycle.
- m0, m1, m2 all request in the same cycle -> grant order m2, m0, m1; three acks, each separated by one IDLE cycle.
- m1 held high while m0 re-requests continuously, STARVE_MAX=4 -> m0 wins 4 times, then m1 wins the 5th arbitration; starve_cnt returns to 0.
- m2 write 0x0000_0010 with data 0x5A5A_5A5A, 0-wait slave -> s_we_o=1, s_wdata_o=0x5A5A_5A5A; m2_ack_o one cycle later; hold_flag_o stays 0 throughout.
- rst pulsed during a BUSY m0 read -> s_req_o=0 and m0_ack_o=0 immediately; after release the held m0 request is re-arbitrated and completes.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=64 and a slave that never acks -> after 64 BUSY cycles m0_ack_o=1, err_o=1, m0_rdata_o=0; state returns to IDLE.
